msi_bus_arbiter: RTL
====================

MSI_BUS_ARBITER -- requirements
Module: msi_bus_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of cache controllers sharing the snoop bus.
REQ-002 The block SHALL have parameter AW, default 32, block address width.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port req, input, NREQ, per-controller bus request, held until done.
REQ-006 The block SHALL have port req_msg, input, 2*NREQ, packed per-controller bus message (00 INVALIDATE, 01 WRITE_MISS, 10 READ_MISS, 11 illegal).
REQ-007 The block SHALL have port req_addr, input, AW*NREQ, packed per-controller block address.
REQ-008 The block SHALL have port gnt, output, NREQ, one-hot grant.
REQ-009 The block SHALL have port done, output, NREQ, one-hot one-cycle completion pulse.
REQ-010 The block SHALL have ports snoop_valid (output, 1), snoop_msg (output, 2), snoop_addr (output, AW) and snoop_src (output, NREQ, one-hot), forming the broadcast snoop.
REQ-011 The block SHALL have port snoop_wb, input, NREQ, per-controller "holds block MODIFIED, write-back needed" response.
REQ-012 The block SHALL have port wb_done, input, 1, memory write-back complete.
REQ-013 The block SHALL have port mem_req (output, 1) and mem_ack (input, 1), the memory fill handshake.
REQ-014 The block SHALL have ports busy (output, 1, transaction in flight) and error (output, 1, timeout pulse).

Function
REQ-015 The FSM SHALL have states IDLE, SNOOP, WB, MEM, DONE.
REQ-016 IDLE: when req is non-zero, the block SHALL pick the winner round-robin starting at index rr_ptr+1 (mod NREQ), latch its msg and addr, and enter SNOOP next edge.
REQ-017 gnt[winner] SHALL be 1 from SNOOP through DONE inclusive, 0 otherwise; busy SHALL equal (state != IDLE).
REQ-018 SNOOP SHALL last exactly one cycle with snoop_valid=1 and snoop_msg, snoop_addr, snoop_src driven from the latched values; snoop_valid SHALL be 0 in all other states.
REQ-019 In SNOOP the block SHALL sample snoop_wb with the winner's bit masked: any bit set -> WB; else INVALIDATE -> DONE; else -> MEM.
REQ-020 A latched msg of 11 SHALL bypass SNOOP (IDLE -> DONE directly, no snoop_valid, no memory access).
REQ-021 WB SHALL wait for wb_done, then go to DONE for INVALIDATE, else to MEM.
REQ-022 MEM SHALL hold mem_req=1 until mem_ack is sampled high, then go to DONE.
REQ-023 DONE SHALL last one cycle with done[winner]=1, set rr_ptr to the winner, and return to IDLE.
REQ-024 wb_done and mem_ack outside WB and MEM respectively SHALL be ignored.
REQ-025 Deassertion of req mid-transaction SHALL NOT abort it; new requests arriving while busy SHALL wait until IDLE.
REQ-026 An uncontended INVALIDATE SHALL produce the done pulse 2 cycles after req is first sampled (SNOOP, then DONE).

Reset
REQ-027 On reset the block SHALL immediately enter IDLE with rr_ptr=NREQ-1 and every output at 0, including mid-transaction, with no done pulse issued.

Configuration
REQ-028 With ARB_TIMEOUT_EN defined, a 4-bit counter SHALL clear on entry to WB or MEM and count each cycle in them; on the 15th cycle without the handshake the FSM SHALL go to DONE and pulse error=1 for the DONE cycle.
REQ-029 Without ARB_TIMEOUT_EN, WB and MEM SHALL wait indefinitely and error SHALL be tied 0.

Verification
REQ-030 req=0001 with msg=00 and snoop_wb=0 -> snoop_valid in cycle 1, done=0001 in cycle 2, no mem_req.
REQ-031 req=0110 with both reads, rr_ptr=3 -> controller 1 served first, then 2; gnt never multi-hot.
REQ-032 Controller 0 READ_MISS, snoop_wb=0100 -> WB; wb_done after 3 cycles -> MEM; mem_ack -> done=0001; snoop_wb bit 0 set alone -> no WB.
REQ-033 msg=11 -> done pulse one cycle after grant, snoop_valid never asserted.
REQ-034 reset asserted during MEM -> all outputs 0 immediately, IDLE, subsequent request served normally.
REQ-035 With ARB_TIMEOUT_EN, mem_ack held low -> error and done pulse together on the 15th MEM cycle; without the macro -> MEM held indefinitely, error stays 0.

Source files
------------

// File: rtl/msi_bus_arbiter.sv
// ============================================================================
// msi_bus_arbiter : round-robin snoop-bus arbiter for MSI cache controllers
// Optional feature macro: ARB_TIMEOUT_EN (WB/MEM handshake timeout + error)
// Revision: 1.0
// ============================================================================
`default_nettype none

module msi_bus_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_msg,
    input  logic [AW*NREQ-1:0]   req_addr,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 snoop_valid,
    output logic [1:0]           snoop_msg,
    output logic [AW-1:0]        snoop_addr,
    output logic [NREQ-1:0]      snoop_src,
    input  logic [NREQ-1:0]      snoop_wb,
    input  logic                 wb_done,
    output logic                 mem_req,
    input  logic                 mem_ack,
    output logic                 busy,
    output logic                 error
);

    localparam int               c_PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_PW-1:0]  c_LAST     = c_PW'(NREQ - 1);
    localparam logic [NREQ-1:0]  c_ONE      = NREQ'(1);
    localparam logic [1:0]       c_MSG_INV  = 2'b00;
    localparam logic [1:0]       c_MSG_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNOOP = 3'd1,
        WB    = 3'd2,
        MEM   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [c_PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [c_PW-1:0]   win_q, win_d;
    logic [1:0]        msg_q, msg_d;
    logic [AW-1:0]     addr_q, addr_d;

    logic [1:0]        w_msg_arr  [NREQ];
    logic [AW-1:0]     w_addr_arr [NREQ];
    logic [c_PW-1:0]   w_cand;
    logic [c_PW-1:0]   w_pick_idx;
    logic              w_pick_found;
    logic [NREQ-1:0]   w_win_oh;
    logic              w_timeout;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_msg_arr[gi]  = req_msg[2*gi +: 2];
            assign w_addr_arr[gi] = req_addr[AW*gi +: AW];
        end
    endgenerate

    // Scan starts one past the last winner and wraps, so the last winner is checked last.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_cand       = rr_ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = (w_cand == c_LAST) ? '0 : w_cand + 1'b1;
            if (!w_pick_found && req[w_cand]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    assign w_win_oh = c_ONE << win_q;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        msg_d    = msg_q;
        addr_d   = addr_q;
        case (state_q)
            IDLE: begin
                if (w_pick_found) begin
                    win_d   = w_pick_idx;
                    msg_d   = w_msg_arr[w_pick_idx];
                    addr_d  = w_addr_arr[w_pick_idx];
                    state_d = (w_msg_arr[w_pick_idx] == c_MSG_ILL) ? DONE : SNOOP;
                end
            end
            SNOOP: begin
                // The requester's own MODIFIED response never forces a write-back.
                if (|(snoop_wb & ~w_win_oh))
                    state_d = WB;
                else if (msg_q == c_MSG_INV)
                    state_d = DONE;
                else
                    state_d = MEM;
            end
            WB: begin
                if (wb_done)
                    state_d = (msg_q == c_MSG_INV) ? DONE : MEM;
                else if (w_timeout)
                    state_d = DONE;
            end
            MEM: begin
                if (mem_ack || w_timeout)
                    state_d = DONE;
            end
            DONE: begin
                rr_ptr_d = win_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= c_LAST;
            win_q    <= '0;
            msg_q    <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            msg_q    <= msg_d;
            addr_q   <= addr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [3:0] c_TMO_LAST = 4'd14;

    logic [3:0] tmo_cnt_q, tmo_cnt_d;
    logic       err_q, err_d;
    logic       w_wait_state;

    assign w_wait_state = (state_q == WB) || (state_q == MEM);
    assign w_timeout    = w_wait_state && (tmo_cnt_q == c_TMO_LAST);

    // Counter restarts whenever a wait state is entered, including WB -> MEM.
    always_comb begin
        tmo_cnt_d = (w_wait_state && (state_d == state_q)) ? tmo_cnt_q + 4'd1 : 4'd0;
        err_d     = w_timeout && (((state_q == WB) && !wb_done) ||
                                  ((state_q == MEM) && !mem_ack));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign error = (state_q == DONE) && err_q;
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    assign busy        = (state_q != IDLE);
    assign gnt         = busy ? w_win_oh : '0;
    assign done        = (state_q == DONE) ? w_win_oh : '0;
    assign snoop_valid = (state_q == SNOOP);
    assign snoop_msg   = snoop_valid ? msg_q : '0;
    assign snoop_addr  = snoop_valid ? addr_q : '0;
    assign snoop_src   = snoop_valid ? w_win_oh : '0;
    assign mem_req     = (state_q == MEM);

endmodule

`default_nettype wire
